// File: rtl/bram_dp_param.sv
// Dual-port block RAM: port A read/write with byte enables, port B read-only, self-clearing
// after reset/CLR. Define BRAM_DP_OUTREG_EN to add one output register per port (latency 2).
module bram_dp_param #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 11,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CLR,
    output logic                READY,
    input  logic                ENA,
    input  logic [DATA_W/8-1:0] WEA,
    input  logic [ADDR_W-1:0]   AA,
    input  logic [DATA_W-1:0]   DiA,
    output logic [DATA_W-1:0]   DoA,
    input  logic                ENB,
    input  logic [ADDR_W-1:0]   AB,
    output logic [DATA_W-1:0]   DoB,
    output logic                ERR
);
    localparam int NB     = int'(DATA_W / 8);
    localparam int OFFS_W = $clog2(NB);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [MEM_AW-1:0] LAST    = MEM_AW'(DEPTH - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e            state_q;
    logic [MEM_AW-1:0] cnt_q;
    logic              ready_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_a_q;
    logic [DATA_W-1:0] rd_b_q;

    logic [ADDR_W-1:0] idx_a;
    logic [ADDR_W-1:0] idx_b;
    logic              in_a;
    logic              in_b;
    logic              acc_a;
    logic              acc_b;
    logic              oor;

    // Byte-offset bits are dropped by the shift; the remaining index is range-checked in full.
    assign idx_a = AA >> OFFS_W;
    assign idx_b = AB >> OFFS_W;
    assign in_a  = idx_a < DEPTH_A;
    assign in_b  = idx_b < DEPTH_A;
    assign acc_a = ENA && ready_q && in_a;
    assign acc_b = ENB && ready_q && in_b;
    assign oor   = ready_q && ((ENA && !in_a) || (ENB && !in_b));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StClear;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (CLR) begin
                err_q <= 1'b0;
            end else if (oor) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StClear: begin
                    if (CLR) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (CLR) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // acc_a is never true during the clear pass, so the two write sources are exclusive.
    always_ff @(posedge CLK) begin
        if (state_q == StClear) begin
            mem[cnt_q] <= '0;
        end else if (acc_a) begin
            for (int i = 0; i < NB; i++) begin
                if (WEA[i]) begin
                    mem[idx_a[MEM_AW-1:0]][8*i +: 8] <= DiA[8*i +: 8];
                end
            end
        end
    end

    // Reads sample the array before this edge's write lands, giving read-first collisions.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= acc_a ? mem[idx_a[MEM_AW-1:0]] : '0;
            rd_b_q <= acc_b ? mem[idx_b[MEM_AW-1:0]] : '0;
        end
    end

`ifdef BRAM_DP_OUTREG_EN
    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            out_a_q <= rd_a_q;
            out_b_q <= rd_b_q;
        end
    end

    assign DoA = out_a_q;
    assign DoB = out_b_q;
`else
    assign DoA = rd_a_q;
    assign DoB = rd_b_q;
`endif

    assign READY = ready_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_bram_dp_param.sv
// Self-checking bench for bram_dp_param: directed scenarios plus random traffic against a
// behavioural memory model. Honours BRAM_DP_OUTREG_EN for the expected read latency.
module tb_bram_dp_param;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 11;
    localparam int ADDR_W = 12;
    localparam int NB     = DATA_W / 8;
`ifdef BRAM_DP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              CLR;
    logic              READY;
    logic              ENA;
    logic [NB-1:0]     WEA;
    logic [ADDR_W-1:0] AA;
    logic [DATA_W-1:0] DiA;
    logic [DATA_W-1:0] DoA;
    logic              ENB;
    logic [ADDR_W-1:0] AB;
    logic [DATA_W-1:0] DoB;
    logic              ERR;

    bram_dp_param #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .CLR  (CLR),
        .READY(READY),
        .ENA  (ENA),
        .WEA  (WEA),
        .AA   (AA),
        .DiA  (DiA),
        .DoA  (DoA),
        .ENB  (ENB),
        .AB   (AB),
        .DoB  (DoB),
        .ERR  (ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model: word array, words of the clear pass completed, sticky error, and
    // a read-data delay line of LAT entries per port.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_pos;
    bit                m_err;
    logic [DATA_W-1:0] m_pa [LAT];
    logic [DATA_W-1:0] m_pb [LAT];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        CLR = 1'b0;
        ENA = 1'b0;
        ENB = 1'b0;
        WEA = '0;
        AA  = '0;
        AB  = '0;
        DiA = '0;
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_err = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            m_pa[i] = '0;
            m_pb[i] = '0;
        end
    endtask

    // Predict one clock edge from the current inputs, advance, then compare at the negedge.
    task automatic cycle();
        int                ia;
        int                ib;
        bit                rdy;
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;
        ia  = int'(AA) / NB;
        ib  = int'(AB) / NB;
        rdy = (m_pos == DEPTH);
        ra  = (ENA && rdy && ia < DEPTH) ? m_mem[ia] : '0;
        rb  = (ENB && rdy && ib < DEPTH) ? m_mem[ib] : '0;
        if (CLR) m_err = 1'b0;
        else if (rdy && ((ENA && ia >= DEPTH) || (ENB && ib >= DEPTH))) m_err = 1'b1;
        if (rdy && ENA && ia < DEPTH) begin
            for (int b = 0; b < NB; b++) begin
                if (WEA[b]) m_mem[ia][8*b +: 8] = DiA[8*b +: 8];
            end
        end
        if (CLR) begin
            m_pos = 0;
        end else if (!rdy) begin
            m_pos++;
            if (m_pos == DEPTH) begin
                for (int w = 0; w < DEPTH; w++) m_mem[w] = '0;
            end
        end
        for (int i = LAT - 1; i > 0; i--) begin
            m_pa[i] = m_pa[i-1];
            m_pb[i] = m_pb[i-1];
        end
        m_pa[0] = ra;
        m_pb[0] = rb;
        @(posedge CLK);
        @(negedge CLK);
        chk("ready", DATA_W'(READY), DATA_W'(m_pos == DEPTH));
        chk("err", DATA_W'(ERR), DATA_W'(m_err));
        chk("doa", DoA, m_pa[LAT-1]);
        chk("dob", DoB, m_pb[LAT-1]);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            cycle();
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!READY && n < 50) begin
            idle();
            cycle();
            n++;
        end
    endtask

    task automatic async_reset();
        #2 RST_N = 1'b0;
        #1;
        chk("rst_ready", DATA_W'(READY), '0);
        chk("rst_err", DATA_W'(ERR), '0);
        chk("rst_doa", DoA, '0);
        chk("rst_dob", DoB, '0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        int n;
        idle();
        RST_N = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk("init_ready", DATA_W'(READY), '0);
        chk("init_err", DATA_W'(ERR), '0);
        chk("init_doa", DoA, '0);
        chk("init_dob", DoB, '0);
        RST_N = 1'b1;

        // Initial clear pass, then every in-range word reads back as zero.
        wait_ready(n);
        chk("clear_cycles", DATA_W'(n), DATA_W'(DEPTH));
        for (int a = 0; a <= 'h28; a += 4) begin
            idle();
            ENA = 1'b1;
            AA  = ADDR_W'(a);
            ENB = 1'b1;
            AB  = ADDR_W'(a);
            cycle();
        end
        idle_cycles(LAT);

        // Byte-lane write.
        idle();
        ENA = 1'b1; WEA = 4'hF; AA = 'h08; DiA = 32'h1122_3344;
        cycle();
        WEA = 4'b0101; DiA = 32'hAABB_CCDD;
        cycle();
        idle();
        ENB = 1'b1; AB = 'h08;
        cycle();
        idle_cycles(LAT - 1);
        chk("byte_lane", DoB, 32'h11BB_33DD);

        // Read-first collision on both ports.
        idle();
        ENA = 1'b1; WEA = 4'hF; AA = 'h0C; DiA = 32'h9;
        cycle();
        ENA = 1'b1; WEA = 4'hF; AA = 'h0C; DiA = 32'h5;
        ENB = 1'b1; AB = 'h0E;
        cycle();
        idle_cycles(LAT - 1);
        chk("collide_b_old", DoB, 32'h9);
        chk("collide_a_old", DoA, 32'h9);
        idle();
        ENB = 1'b1; AB = 'h0C;
        cycle();
        idle_cycles(LAT - 1);
        chk("collide_b_new", DoB, 32'h5);

        // Out-of-range write is dropped and sets the sticky error.
        idle();
        ENA = 1'b1; WEA = 4'hF; AA = 'h2C; DiA = 32'hDEAD_BEEF;
        cycle();
        idle_cycles(LAT - 1);
        chk("oor_doa", DoA, '0);
        chk("oor_err", DATA_W'(ERR), 1);
        idle_cycles(3);
        chk("oor_err_sticky", DATA_W'(ERR), 1);
        idle();
        CLR = 1'b1;
        cycle();
        chk("clr_err", DATA_W'(ERR), '0);
        n = 1;
        while (!READY && n < 50) begin
            idle();
            cycle();
            if (!READY) n++;
        end
        chk("clr_ready_low", DATA_W'(n), DATA_W'(DEPTH));

        // Accesses during the clear pass are ignored.
        idle();
        CLR = 1'b1;
        cycle();
        idle_cycles(4);
        for (int i = 0; i < 4; i++) begin
            idle();
            ENA = 1'b1; WEA = 4'hF; AA = 'h00; DiA = 32'h1;
            ENB = 1'b1; AB = 'h2C;
            cycle();
        end
        wait_ready(n);
        chk("clear_err_unchanged", DATA_W'(ERR), '0);
        idle();
        ENB = 1'b1; AB = 'h00;
        cycle();
        idle_cycles(LAT - 1);
        chk("clear_write_ignored", DoB, '0);

        // Asynchronous reset from RUN with live data and error, then again mid-clear.
        idle();
        ENA = 1'b1; WEA = 4'hF; AA = 'h10; DiA = 32'hCAFE_F00D;
        cycle();
        idle();
        ENB = 1'b1; AB = 'h10;
        ENA = 1'b1; AA = 'h2C;
        cycle();
        idle_cycles(LAT - 1);
        chk("pre_rst_dob", DoB, 32'hCAFE_F00D);
        chk("pre_rst_err", DATA_W'(ERR), 1);
        async_reset();
        idle_cycles(5);
        async_reset();
        wait_ready(n);
        chk("rerun_clear_cycles", DATA_W'(n), DATA_W'(DEPTH));

        // Random traffic, including byte-offset addresses, out-of-range and occasional CLR.
        for (int i = 0; i < 400; i++) begin
            CLR = ($urandom_range(0, 63) == 0);
            ENA = 1'($urandom_range(0, 1));
            ENB = 1'($urandom_range(0, 1));
            WEA = NB'($urandom);
            DiA = DATA_W'($urandom);
            if ($urandom_range(0, 9) == 0) AA = ADDR_W'($urandom);
            else AA = ADDR_W'($urandom_range(0, NB * (DEPTH + 2) - 1));
            if ($urandom_range(0, 9) == 0) AB = ADDR_W'($urandom);
            else AB = ADDR_W'($urandom_range(0, NB * (DEPTH + 2) - 1));
            cycle();
        end
        idle_cycles(LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bram_dp_param.md
BRAM_DP_PARAM -- requirements
Module: bram_dp_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter DEPTH, default 11, number of words.
REQ-003 SHALL have parameter ADDR_W, default 12, byte-address width.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST_N, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port CLR, input, 1, a one-cycle pulse that restarts memory clear.
REQ-007 SHALL have port READY, output, 1, high when the memory accepts accesses.
REQ-008 SHALL have ports ENA (input, 1), WEA (input, DATA_W/8), AA (input, ADDR_W), DiA (input, DATA_W) and DoA (output, DATA_W) for port A read/write.
REQ-009 SHALL have ports ENB (input, 1), AB (input, ADDR_W) and DoB (output, DATA_W) for port B, read-only.
REQ-010 SHALL have port ERR, output, 1, a sticky out-of-range access flag.

Function
REQ-011 Word index SHALL be the address shifted right by log2(DATA_W/8); byte offset bits SHALL be ignored.
REQ-012 Write SHALL occur when ENA=1, READY=1, the index is below DEPTH and WEA[i]=1; it updates byte lane i only.
REQ-013 Read latency SHALL be 1 cycle: Do(n+1) = mem[index(n)] when EN(n)=1, else 0.
REQ-014 Reads SHALL return 0 if the index is at or above DEPTH, or if READY(n)=0.
REQ-015 Any out-of-range access with ENA or ENB high while READY=1 SHALL set ERR.
REQ-016 ERR SHALL clear only on reset or CLR.
REQ-017 On a same-address collision (port A write, port B read in the same cycle), DoB SHALL return the old data (read-first).
REQ-018 Port A read with a simultaneous write SHALL also be read-first.
REQ-019 The FSM SHALL have two states, CLEAR and RUN.
REQ-020 In CLEAR, a counter SHALL write zero to words 0..DEPTH-1, one word per cycle, with READY=0.
REQ-021 After writing word DEPTH-1, the FSM SHALL go to RUN and set READY=1 on the next cycle.
REQ-022 CLR in RUN SHALL return the FSM to CLEAR with counter 0; READY SHALL go low the following cycle.
REQ-023 CLR asserted during CLEAR SHALL restart the counter at 0.
REQ-024 Port accesses during CLEAR SHALL be ignored: no write, Do=0, ERR unchanged.

Reset
REQ-025 RST_N=0 SHALL asynchronously force state=CLEAR, counter=0, READY=0, ERR=0, DoA=0, DoB=0, output pipeline registers=0.
REQ-026 Memory contents SHALL be defined only after the CLEAR pass completes; reset asserted mid-clear SHALL restart the pass from word 0.
REQ-027 Release of RST_N SHALL start the clear on the first following CLK edge.

Configuration
REQ-028 Macro BRAM_DP_OUTREG_EN, when defined, SHALL add one output register stage per port, giving read latency 2 cycles; the extra register resets to 0.
REQ-029 Without BRAM_DP_OUTREG_EN, read latency SHALL be 1 cycle.
REQ-030 The macro SHALL NOT alter write, clear, ERR or collision behaviour.

Verification (defaults DATA_W=32, DEPTH=11, macro undefined unless stated)
REQ-031 Release RST_N, hold ENA/ENB=0 -> READY=0 for 11 cycles, then 1; reads of all addresses 0x00..0x28 return 0.
REQ-032 Write AA=0x08, WEA=0b0101, DiA=0xAABBCCDD over 0x11223344 -> next-cycle ENB read of 0x08 gives 0x11BB33DD; latency 2 with BRAM_DP_OUTREG_EN.
REQ-033 Same-cycle write AA=0x0C DiA=0x5 and read AB=0x0C (old value 0x9) -> DoB=0x9 next cycle, 0x5 on the following read.
REQ-034 Access AA=0x2C (index 11) with WEA=0xF -> no write, DoA=0, ERR=1 and stays 1; a CLR pulse -> ERR=0, READY low for 11 cycles.
REQ-035 Assert RST_N=0 at clear word 5 -> READY, ERR and Do go to 0 immediately; after release the full 11-cycle clear reruns.
REQ-036 Write during CLEAR (ENA=1, WEA=0xF, AA=0x00, DiA=0x1) -> ignored; after READY, a read of 0x00 gives 0.
